systolic_row_ctrl: RTL and testbench
====================================

# systolic_row_ctrl

Sequencer for a column of PE rows in the weight-stationary systolic tile. Preloads one tile of weights by driving the rows' shared `w_en` while weight rows stream down from the weight source, then drives `w_compute` while a programmed number of activation vectors is injected at the left edge. It also flags the cycles in which the bottom-row `out_sum` bus carries a valid result. Sits between the tile-level command interface and the array of row instances.

## Interface
- `ROWS`, 11: PE rows in the tile; also the number of weight beats per preload.
- `COLS`, 11: PE columns per row (`w_tile_column_size`).
- `LAT`, `ROWS+COLS-1`: cycles from activation accept to valid result at the array output.
- `VEC_W`, 16: width of the vector-count field.

- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin one tile job; sampled only in IDLE.
- `num_vec`  in  VEC_W  activation vectors in the job; sampled with `start`.
- `w_valid`  in  1  weight source has a weight row on `in_weight_above`.
- `w_ready`  out  1  controller accepts a weight row this cycle.
- `a_valid`  in  1  activation source has a vector on `active_left`.
- `a_ready`  out  1  controller accepts an activation this cycle.
- `w_en`  out  1  to every row: shift weights down one row.
- `w_compute`  out  1  to every row: MAC/propagate enable.
- `a_bubble`  out  1  steers a zero onto `active_left` instead of source data.
- `out_valid`  out  1  bottom `out_sum` holds a result this cycle.
- `out_last`  out  1  with `out_valid`: result of the final vector.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle pulse, job complete.

## Operation
- States: IDLE, LOAD_W, GAP, COMPUTE, DRAIN, DONE.
- IDLE:
  - `start` with `num_vec`≠0 latches `num_vec` and goes to LOAD_W.
  - `start` with `num_vec`=0 goes straight to DONE.
  - `start` in any other state is ignored.
- LOAD_W:
  - `w_ready`=1; `w_en`=`w_valid` (combinational). The array stalls when the source stalls.
  - Weight counter counts accepted beats. When beat ROWS is accepted, go to GAP.
- GAP: exactly one cycle with `w_en`=`w_compute`=0, then COMPUTE.
- COMPUTE:
  - `w_compute`=1, `a_ready`=1, `a_bubble`=!`a_valid`. The array never stalls; a missing activation becomes a zero bubble.
  - Each accept (`a_valid`&`a_ready`) increments the vector counter. Accept number `num_vec` goes to DRAIN.
- DRAIN: `w_compute`=1, `a_bubble`=1, `a_ready`=0 for exactly LAT cycles, then DONE.
- DONE: `done`=1 for one cycle, then IDLE. `busy` is 0 in IDLE only.
- Result tracking:
  - A LAT-deep delay line carries {accept, is_last} for every COMPUTE cycle.
  - `out_valid`/`out_last` are the delay-line output.
  - Bubbles insert 0s, so gaps in `out_valid` mirror gaps in `a_valid`.
- Counter widths:
  - Weight counter: clog2(ROWS+1).
  - Vector counter: VEC_W.
  - Drain counter: clog2(LAT+1).
  - No wrap: `num_vec`=2^VEC_W−1 completes normally.

## Timing
- Reset, and every output's reset value:
  - With `rst` high at an edge, the next cycle is in IDLE.
  - All outputs are 0, all counters are 0 and the delay line is cleared.
  - This applies from any state, including mid-LOAD_W and mid-DRAIN. No `done` is emitted for an aborted job.
- `start` sampled at edge 0 puts the controller in LOAD_W from cycle 1. With `w_valid` held high, LOAD_W covers cycles 1..ROWS.
- Accept sampled at edge t gives `out_valid`=1 in cycle t+LAT.
- The last accept at edge t gives DRAIN in cycles t+1..t+LAT and `done` in cycle t+LAT+1. The final `out_valid`/`out_last` coincides with the last DRAIN cycle.
- `w_en` and `w_compute` are never both 1.
- `w_ready`/`a_ready` depend on state only, never on `w_valid`/`a_valid`.

## Structure
- Package `systolic_ctrl_pkg` holds:
  - the state enum;
  - the function computing the default LAT from ROWS and COLS;
  - the VEC_W default.
- Sub-module `valid_delay_line` (parameters DEPTH, WIDTH): synchronous-reset shift register used for the `out_valid`/`out_last` tracking.
- All remaining logic, i.e. the FSM and the three counters, lives in `systolic_row_ctrl`.

## Test plan
All scenarios use ROWS=COLS=4, LAT=7.
- Reset: `rst` high 2 cycles → all outputs 0, `busy`=0; `start` asserted together with `rst` is ignored.
- Nominal: `start`, `num_vec`=3, `w_valid`=`a_valid`=1 → `w_en` in cycles 1–4, GAP in cycle 5, `a_ready` in 6–8, `out_valid` in 13–15 with `out_last` in 15, `done` only in 16.
- Weight stall: `w_valid` alternating 1,0 → exactly 4 `w_en` pulses aligned to `w_valid`=1; LOAD_W lasts 8 cycles.
- Activation bubbles: `num_vec`=4, `a_valid` pattern 1,0,1,1,0,1 → `a_bubble` high on the 0 cycles; `out_valid` replicates the pattern 7 cycles later; `done` arrives 8 cycles after the 4th accept.
- Zero job: `start` with `num_vec`=0 → `done` in cycle 1; `w_en`, `w_compute`, `a_ready` never assert.
- Abort: `rst` in 2nd COMPUTE cycle → IDLE next cycle, outputs 0, no `done`; a following `start` with `num_vec`=1 runs the nominal sequence from cycle 1.

Source files
------------

// File: rtl/systolic_ctrl_pkg.sv
// Shared types and defaults for the systolic tile row sequencer.
package systolic_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_W,
    ST_GAP,
    ST_COMPUTE,
    ST_DRAIN,
    ST_DONE
  } ctrl_state_e;

  localparam int VEC_W_DEFAULT = 16;

  // Skew of a weight-stationary array: first result leaves the bottom-right PE after rows+cols-1 cycles.
  function automatic int calc_lat(input int rows, input int cols);
    return rows + cols - 1;
  endfunction

endpackage

// File: rtl/valid_delay_line.sv
// Fixed-depth shift register that tracks result flags through the array skew.
module valid_delay_line #(
  parameter int DEPTH = 7,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stages [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
    end else begin
      stages[0] <= din;
      for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  assign dout = stages[DEPTH-1];

endmodule

// File: rtl/systolic_row_ctrl.sv
// Tile job sequencer: weight preload, activation injection, drain, and result-valid tracking.
module systolic_row_ctrl
  import systolic_ctrl_pkg::*;
#(
  parameter int ROWS  = 11,
  parameter int COLS  = 11,
  parameter int LAT   = calc_lat(ROWS, COLS),
  parameter int VEC_W = VEC_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [VEC_W-1:0] num_vec,
  input  logic             w_valid,
  output logic             w_ready,
  input  logic             a_valid,
  output logic             a_ready,
  output logic             w_en,
  output logic             w_compute,
  output logic             a_bubble,
  output logic             out_valid,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  localparam int WCNT_W = $clog2(ROWS + 1);
  localparam int DCNT_W = $clog2(LAT + 1);
  localparam logic [WCNT_W-1:0] W_LAST     = WCNT_W'(ROWS - 1);
  localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(LAT - 1);

  ctrl_state_e        state, next_state;
  logic [WCNT_W-1:0]  w_cnt;
  logic [VEC_W-1:0]   vec_cnt;
  logic [VEC_W-1:0]   num_vec_q;
  logic [DCNT_W-1:0]  drain_cnt;
  logic               accept;
  logic               last_vec;

  assign accept   = (state == ST_COMPUTE) && a_valid;
  // Compare against num_vec-1 so an all-ones count finishes without the counter wrapping.
  assign last_vec = (vec_cnt == (num_vec_q - VEC_W'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      w_cnt     <= '0;
      vec_cnt   <= '0;
      num_vec_q <= '0;
      drain_cnt <= '0;
    end else begin
      state <= next_state;
      case (state)
        ST_IDLE: begin
          w_cnt     <= '0;
          vec_cnt   <= '0;
          drain_cnt <= '0;
          if (start && (num_vec != '0)) num_vec_q <= num_vec;
        end
        ST_LOAD_W:  if (w_valid) w_cnt <= w_cnt + WCNT_W'(1);
        ST_COMPUTE: if (accept) vec_cnt <= vec_cnt + VEC_W'(1);
        ST_DRAIN:   drain_cnt <= drain_cnt + DCNT_W'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    next_state = state;
    w_ready    = 1'b0;
    w_en       = 1'b0;
    w_compute  = 1'b0;
    a_ready    = 1'b0;
    a_bubble   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) next_state = (num_vec == '0) ? ST_DONE : ST_LOAD_W;
      end
      ST_LOAD_W: begin
        w_ready = 1'b1;
        w_en    = w_valid;
        if (w_valid && (w_cnt == W_LAST)) next_state = ST_GAP;
      end
      ST_GAP: next_state = ST_COMPUTE;
      ST_COMPUTE: begin
        // The array keeps moving every cycle; a missing activation is replaced by a zero.
        w_compute = 1'b1;
        a_ready   = 1'b1;
        a_bubble  = !a_valid;
        if (accept && last_vec) next_state = ST_DRAIN;
      end
      ST_DRAIN: begin
        w_compute = 1'b1;
        a_bubble  = 1'b1;
        if (drain_cnt == DRAIN_LAST) next_state = ST_DONE;
      end
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  valid_delay_line #(
    .DEPTH (LAT),
    .WIDTH (2)
  ) u_valid_delay (
    .clk  (clk),
    .rst  (rst),
    .din  ({accept, accept && last_vec}),
    .dout ({out_valid, out_last})
  );

endmodule

// File: tb/tb_systolic_row_ctrl.sv
// Self-checking bench for systolic_row_ctrl with a cycle-timeline reference model (ROWS=COLS=4).
module tb_systolic_row_ctrl;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int LAT   = 7;
  localparam int VEC_W = 16;
  localparam int MAXC  = 400;

  localparam int B_WRDY = 0, B_WEN = 1, B_WCMP = 2, B_ARDY = 3, B_ABUB = 4,
                 B_OVLD = 5, B_OLST = 6, B_BUSY = 7, B_DONE = 8;

  logic             clk = 1'b0;
  logic             rst, start, w_valid, a_valid;
  logic [VEC_W-1:0] num_vec;
  logic             w_ready, a_ready, w_en, w_compute, a_bubble;
  logic             out_valid, out_last, busy, done;

  int checks = 0;
  int errors = 0;
  int job_end;
  logic       wv [MAXC];
  logic       av [MAXC];
  logic [8:0] e  [MAXC];
  string      names [9];

  always #5 clk = ~clk;

  systolic_row_ctrl #(
    .ROWS  (ROWS),
    .COLS  (COLS),
    .VEC_W (VEC_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_vec   (num_vec),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .w_en      (w_en),
    .w_compute (w_compute),
    .a_bubble  (a_bubble),
    .out_valid (out_valid),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  // Expected per-cycle outputs of one job started in cycle 0, walked phase by phase.
  task automatic build_model(input int nv);
    int c, beats, acc;
    for (int i = 0; i < MAXC; i++) e[i] = '0;
    if (nv == 0) begin
      e[1][B_BUSY] = 1'b1;
      e[1][B_DONE] = 1'b1;
      job_end = 1;
      return;
    end
    c = 1;
    beats = 0;
    while (beats < ROWS && c < MAXC - 2*LAT) begin
      e[c][B_BUSY] = 1'b1;
      e[c][B_WRDY] = 1'b1;
      e[c][B_WEN]  = wv[c];
      if (wv[c]) beats++;
      c++;
    end
    e[c][B_BUSY] = 1'b1;
    c++;
    acc = 0;
    while (acc < nv && c < MAXC - 2*LAT) begin
      e[c][B_BUSY] = 1'b1;
      e[c][B_WCMP] = 1'b1;
      e[c][B_ARDY] = 1'b1;
      e[c][B_ABUB] = !av[c];
      if (av[c]) begin
        acc++;
        e[c+LAT][B_OVLD] = 1'b1;
        if (acc == nv) e[c+LAT][B_OLST] = 1'b1;
      end
      c++;
    end
    for (int k = 0; k < LAT; k++) begin
      e[c][B_BUSY] = 1'b1;
      e[c][B_WCMP] = 1'b1;
      e[c][B_ABUB] = 1'b1;
      c++;
    end
    e[c][B_BUSY] = 1'b1;
    e[c][B_DONE] = 1'b1;
    job_end = c;
  endtask

  task automatic applyStimulus(input int c, input int nv, input logic do_rst);
    rst     = do_rst;
    start   = (c == 0);
    num_vec = (c == 0) ? VEC_W'(nv) : VEC_W'($urandom);
    w_valid = wv[c];
    a_valid = av[c];
  endtask

  task automatic checkOutput(input int c, input logic [8:0] exp, input string phase);
    logic [8:0] obs;
    obs = {done, busy, out_last, out_valid, a_bubble, a_ready, w_compute, w_en, w_ready};
    for (int i = 0; i < 9; i++) begin
      checks++;
      assert (obs[i] === exp[i]) else begin
        errors++;
        $error("[TB] FAIL %s.%s cycle %0d: observed %b expected %b", phase, names[i], c, obs[i], exp[i]);
      end
    end
  endtask

  // Runs one job through to the first idle cycle after done, or until a reset aborts it.
  task automatic run_job(input int nv, input int abort_at, input string phase);
    build_model(nv);
    for (int c = 0; c <= job_end + 1; c++) begin
      applyStimulus(c, nv, c == abort_at);
      @(negedge clk);
      checkOutput(c, e[c], phase);
      @(posedge clk);
      #1;
      if (c == abort_at) begin
        rst = 1'b0;
        start = 1'b0;
        w_valid = 1'b1;
        a_valid = 1'b1;
        for (int k = 0; k < LAT + 2; k++) begin
          @(negedge clk);
          checkOutput(c + 1 + k, 9'b0, {phase, "_after_rst"});
          @(posedge clk);
          #1;
        end
        return;
      end
    end
  endtask

  task automatic fill_ones();
    for (int i = 0; i < MAXC; i++) begin
      wv[i] = 1'b1;
      av[i] = 1'b1;
    end
  endtask

  initial begin
    logic [5:0] bub_pat;
    names = '{"w_ready", "w_en", "w_compute", "a_ready", "a_bubble",
              "out_valid", "out_last", "busy", "done"};

    rst = 1'b1; start = 1'b1; num_vec = 16'd5; w_valid = 1'b1; a_valid = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput(0, 9'b0, "reset");
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    checkOutput(1, 9'b0, "reset_release");
    @(posedge clk); #1;

    $display("[TB] nominal job");
    fill_ones();
    run_job(3, -1, "nominal");

    $display("[TB] weight stall");
    fill_ones();
    for (int i = 0; i < MAXC; i++) wv[i] = (i % 2 == 0);
    run_job(2, -1, "wstall");

    $display("[TB] activation bubbles");
    fill_ones();
    bub_pat = 6'b101101;
    for (int i = 0; i < 6; i++) av[6 + i] = bub_pat[5 - i];
    run_job(4, -1, "bubbles");

    $display("[TB] zero job");
    fill_ones();
    run_job(0, -1, "zero");

    $display("[TB] abort in compute");
    fill_ones();
    run_job(3, 7, "abort");
    run_job(1, -1, "post_abort");

    $display("[TB] random jobs");
    for (int j = 0; j < 8; j++) begin
      for (int i = 0; i < MAXC; i++) begin
        wv[i] = (i >= 150) ? 1'b1 : 1'($urandom_range(0, 1));
        av[i] = (i >= 150) ? 1'b1 : 1'($urandom_range(0, 1));
      end
      run_job(int'($urandom_range(1, 6)), -1, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
